// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: digit count, "all off"
// patterns for the active-low segment/anode pins, and the active-low
// hex glyph table (bit 0 = a ... bit 6 = g).
package clock_disp_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0]            SEG_OFF   = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   hex : 4-bit value 0..F
//   seg : active-low segments, bit 0 = a ... bit 6 = g
module hex_to_seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX_F;
    case (hex)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver.
//   clk_osc    : system clock
//   rst        : asynchronous active-high reset
//   digits     : four hex digits, digit k = digits[4k+3:4k], digit 0 rightmost
//   blank_mask : bit k forces digit k dark
//   blink_mask : bit k darkens digit k while the blink phase is 1
//   eSeg       : registered active-low segments (bit 0 = a ... bit 6 = g)
//   anode      : registered active-low digit enables, anode[k] = digit k
//   frame_tick : one-cycle pulse when a new input snapshot takes effect
// Inputs are sampled only at frame end so one scan frame never mixes old
// and new values. Each digit slot starts with BLANK_CYC dark cycles to
// suppress ghosting between digits.
module seg_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 2_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk_osc,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  eSeg,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic [6:0]              eseg_q, eseg_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_tick_q, frame_tick_d;

  logic       cnt_end, frame_end, blink_end, dark;
  logic [3:0] cur_digit;
  logic [6:0] cur_glyph;

  // Digit for the current slot comes from the snapshot, never the live input.
  assign cur_digit = snap_digits_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (cur_digit),
    .seg (cur_glyph)
  );

  always_comb begin
    cnt_end   = (cnt_q == CNT_MAX);
    frame_end = cnt_end && (idx_q == 2'd3);
    blink_end = (blink_cnt_q == BLINK_MAX);

    cnt_d       = cnt_end ? '0 : cnt_q + CW'(1);
    idx_d       = cnt_end ? idx_q + 2'd1 : idx_q;
    // Blink runs independently of the scan; a coincident frame end simply
    // starts the next frame with the already-toggled phase.
    blink_cnt_d = blink_end ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_end;

    snap_digits_d = snap_digits_q;
    snap_blank_d  = snap_blank_q;
    snap_blink_d  = snap_blink_q;
    if (frame_end) begin
      snap_digits_d = digits;
      snap_blank_d  = blank_mask;
      snap_blink_d  = blink_mask;
    end
    frame_tick_d = frame_end;

    dark = (cnt_q < BLANK_END) || snap_blank_q[idx_q] ||
           (snap_blink_q[idx_q] && phase_q);

    anode_d = dark ? ANODE_OFF : ~(4'b0001 << idx_q);
    eseg_d  = dark ? SEG_OFF   : cur_glyph;
  end

  // Reset snapshot blanks every digit, so the first frame after reset is dark.
  always_ff @(posedge clk_osc or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      snap_digits_q <= '0;
      snap_blank_q  <= 4'b1111;
      snap_blink_q  <= '0;
      eseg_q        <= SEG_OFF;
      anode_q       <= ANODE_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      snap_digits_q <= snap_digits_d;
      snap_blank_q  <= snap_blank_d;
      snap_blink_q  <= snap_blink_d;
      eseg_q        <= eseg_d;
      anode_q       <= anode_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign eSeg       = eseg_q;
  assign anode      = anode_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2,
// BLINK_DIV=20. t counts clock edges since reset release; the outputs seen
// after edge t belong to scan state s = t-1 (slot = (s/8)%4, cnt = s%8,
// blink phase = (s/20)%2). Snapshots are taken at edges that are multiples
// of 32.
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 20;
  localparam int FR = 4 * SD;

  logic        clk_osc = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic [6:0]  eSeg;
  logic [3:0]  anode;
  logic        frame_tick;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk_osc    (clk_osc),
    .rst        (rst),
    .digits     (digits),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .eSeg       (eSeg),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk_osc = ~clk_osc;

  int          t;
  int          nvec;
  int          nfail;
  logic [15:0] cur_d, prv_d;
  logic [3:0]  cur_b, prv_b, cur_k, prv_k;
  logic [6:0]  glyph [16];

  task automatic vchk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s t=%0d got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    cur_d = 16'h0; cur_b = 4'hF; cur_k = 4'h0;
    prv_d = 16'h0; prv_b = 4'hF; prv_k = 4'h0;
  endtask

  // Advance one edge; record which snapshot governs the state just shown.
  task automatic tick();
    @(posedge clk_osc);
    #1;
    t++;
    prv_d = cur_d; prv_b = cur_b; prv_k = cur_k;
    if (t % FR == 0) begin
      cur_d = digits; cur_b = blank_mask; cur_k = blink_mask;
    end
  endtask

  task automatic check_model();
    int s = t - 1;
    int c = s % SD;
    int k = (s / SD) % 4;
    bit ph = ((s / BD) % 2) == 1;
    logic [3:0] ea;
    logic [6:0] es;
    if (c < BC || prv_b[k] || (prv_k[k] && ph)) begin
      ea = 4'b1111;
      es = 7'b1111111;
    end else begin
      ea = 4'b1111;
      ea[k] = 1'b0;
      es = glyph[prv_d[4*k +: 4]];
    end
    vchk("anode", anode, ea);
    vchk("eseg", eSeg, es);
    vchk("frame_tick", frame_tick, (t % FR == 0));
    vchk("anode_legal",
         anode inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111}, 1);
  endtask

  task automatic run_to(input int tend);
    while (t < tend) begin
      tick();
      check_model();
    end
  endtask

  initial begin
    nvec = 0;
    nfail = 0;
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001;
    glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000;
    glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001;
    glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    model_reset();

    // 1. Reset and first frame
    repeat (2) @(posedge clk_osc);
    #1;
    vchk("rst_anode", anode, 4'b1111);
    vchk("rst_eseg", eSeg, 7'b1111111);
    vchk("rst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    model_reset();
    digits = 16'h1234;
    while (t < 2 * FR) begin
      tick();
      check_model();
      if (t <= FR) vchk("frame1_dark", anode, 4'b1111);
      if (t == 35) begin
        vchk("s0_an", anode, 4'b1110);
        vchk("s0_seg4", eSeg, 7'b0011001);
      end
      if (t == 59) begin
        vchk("s3_an", anode, 4'b0111);
        vchk("s3_seg1", eSeg, 7'b1111001);
      end
    end

    // 2. Dead time and one-hot
    digits = 16'h8888;
    while (t < 6 * FR) begin
      tick();
      check_model();
      if (t > 3 * FR && (t - 1) % SD < BC) vchk("dead_time", anode, 4'b1111);
      if (t > 3 * FR && (t - 1) % SD == BC) vchk("lit_after_dead", anode != 4'b1111, 1);
    end

    // 3. Snapshot atomicity: change in slot 1 of the frame showing zeros
    digits = 16'h0000;
    run_to(7 * FR + SD + 3);
    digits = 16'hFFFF;
    while (t < 9 * FR) begin
      tick();
      check_model();
      if (t == 253) vchk("atomic_old0", eSeg, 7'b1000000);
      if (t == 260) vchk("atomic_newF", eSeg, 7'b0001110);
    end

    // 4. Blank and blink
    digits = 16'h1234;
    blank_mask = 4'b0001;
    blink_mask = 4'b0100;
    while (t < 12 * FR) begin
      tick();
      check_model();
      if (t > 10 * FR && ((t - 1) / SD) % 4 == 0) vchk("blank_s0", anode, 4'b1111);
      if (t == 340) begin
        vchk("blink_lit_an", anode, 4'b1011);
        vchk("blink_lit_seg", eSeg, 7'b0100100);
      end
      if (t == 341) vchk("blink_dark", anode, 4'b1111);
      if (t == 372) vchk("blink_lit2", anode, 4'b1011);
    end

    // 6. Glyph sweep, one value per frame
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    digits = 16'hFEDC;
    run_to(13 * FR);
    digits = 16'hBA98;
    run_to(14 * FR);
    digits = 16'h7654;
    run_to(15 * FR);
    digits = 16'h3210;
    while (t < 17 * FR) begin
      tick();
      check_model();
      if (t == 420) begin
        vchk("sweep_C_an", anode, 4'b1110);
        vchk("sweep_C_seg", eSeg, 7'b1000110);
      end
      if (t == 541) begin
        vchk("sweep_3_an", anode, 4'b0111);
        vchk("sweep_3_seg", eSeg, 7'b0110000);
      end
    end

    // 5. Async reset in slot 2 at cnt=5
    run_to(17 * FR + 2 * SD + 5);
    vchk("pre_rst_lit", anode, 4'b1011);
    rst = 1'b1;
    #1;
    vchk("async_anode", anode, 4'b1111);
    vchk("async_eseg", eSeg, 7'b1111111);
    vchk("async_tick", frame_tick, 1'b0);
    @(posedge clk_osc);
    #1;
    rst = 1'b0;
    model_reset();
    digits = 16'h5A5A;
    while (t < FR + 8) begin
      tick();
      check_model();
      if (t <= FR) vchk("rerst_dark", anode, 4'b1111);
      if (t == 35) vchk("rerst_segA", eSeg, 7'b0001000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
